// File: rtl/gsram_8192x2_arb_pkg.sv
// Shared types and constants for the two-port 8192x2 SRAM arbiter.
// Holds the controller state enum and the packed SRAM port drive bundle.
package gsram_8192x2_arb_pkg;

    localparam int unsigned ABITS = 13;
    localparam int unsigned DBITS = 2;
    localparam int unsigned WORDS = 8192;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic             ce;
        logic             we;
        logic [ABITS-1:0] a;
        logic [DBITS-1:0] d;
    } sram_port_t;

    localparam sram_port_t PORT_IDLE = '0;

endpackage

// File: rtl/gsram_rr_pick.sv
// Round-robin picker: returns the first requesting index at or after the
// pointer, wrapping, and whether any requester was found.
module gsram_rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_valid
);

    localparam int unsigned IW = $clog2(NREQ);

    // Scan offsets 0..NREQ-1 from the pointer; the smallest offset wins.
    always_comb begin
        int unsigned j;
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!o_valid && i_req[j[IW-1:0]]) begin
                o_idx   = j[IW-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gsram_8192x2_arb.sv
// Two-port 8192x2 SRAM front end: clears the whole array after reset or on
// request, then grants up to two requesters per cycle round-robin.
module gsram_8192x2_arb
    import gsram_8192x2_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   clr,
    output logic                   busy,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ABITS-1:0]  addr,
    input  logic [NREQ*DBITS-1:0]  wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [NREQ*DBITS-1:0]  rdata,
    output logic [ABITS-1:0]       A0,
    output logic [DBITS-1:0]       D0,
    output logic                   WE0,
    output logic                   CE0,
    output logic [ABITS-1:0]       A1,
    output logic [DBITS-1:0]       D1,
    output logic                   WE1,
    output logic                   CE1,
    input  logic [DBITS-1:0]       Q0,
    input  logic [DBITS-1:0]       Q1
);

    localparam int unsigned IW = $clog2(NREQ);

    state_t           r_state;
    logic [ABITS-1:0] r_ptr;
    logic [IW-1:0]    r_rr;
    logic             r_rv0;
    logic             r_rv1;
    logic [IW-1:0]    r_ri0;
    logic [IW-1:0]    r_ri1;

    logic             w_v0;
    logic             w_v1;
    logic [IW-1:0]    w_i0;
    logic [IW-1:0]    w_i1;
    logic [IW-1:0]    w_ptr1;
    logic [NREQ-1:0]  w_req1;
    logic             w_run;
    logic             w_conf;
    logic             w_g0;
    logic             w_g1;
    sram_port_t       w_p0;
    sram_port_t       w_p1;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        if (32'(x) >= NREQ - 1) begin
            return '0;
        end
        return x + IW'(1);
    endfunction

    function automatic sram_port_t drive(input logic [IW-1:0] idx);
        sram_port_t p;
        p.ce = 1'b1;
        p.we = we[idx];
        p.a  = addr[idx*ABITS +: ABITS];
        p.d  = wdata[idx*DBITS +: DBITS];
        return p;
    endfunction

    // Second winner searches the remaining requesters starting just past the first.
    assign w_ptr1 = wrap_inc(w_i0);
    assign w_req1 = req & ~(NREQ'(1) << w_i0);

    gsram_rr_pick #(.NREQ(NREQ)) u_pick0 (
        .i_req   (req),
        .i_ptr   (r_rr),
        .o_idx   (w_i0),
        .o_valid (w_v0)
    );

    gsram_rr_pick #(.NREQ(NREQ)) u_pick1 (
        .i_req   (w_req1),
        .i_ptr   (w_ptr1),
        .o_idx   (w_i1),
        .o_valid (w_v1)
    );

    // Same-address pairs involving a write keep only the port0 winner.
    assign w_run  = RSTN && (r_state == RUN) && !clr;
    assign w_conf = (addr[w_i0*ABITS +: ABITS] == addr[w_i1*ABITS +: ABITS])
                    && (we[w_i0] || we[w_i1]);
    assign w_g0   = w_run && w_v0;
    assign w_g1   = w_g0 && w_v1 && !w_conf;
    assign busy   = (r_state == CLEAR);

    always_comb begin
        gnt = '0;
        if (w_g0) begin
            gnt[w_i0] = 1'b1;
        end
        if (w_g1) begin
            gnt[w_i1] = 1'b1;
        end
    end

    // Port drive; everything held at zero while RSTN is low.
    always_comb begin
        w_p0 = PORT_IDLE;
        w_p1 = PORT_IDLE;
        if (RSTN && (r_state == CLEAR)) begin
            w_p0.ce = 1'b1;
            w_p0.we = 1'b1;
            w_p0.a  = r_ptr;
            w_p1.ce = 1'b1;
            w_p1.we = 1'b1;
            w_p1.a  = r_ptr | ABITS'(1);
        end else begin
            if (w_g0) begin
                w_p0 = drive(w_i0);
            end
            if (w_g1) begin
                w_p1 = drive(w_i1);
            end
        end
    end

    assign {CE0, WE0, A0, D0} = w_p0;
    assign {CE1, WE1, A1, D1} = w_p1;

    // SRAM data lands one cycle after the access; route it by the stored tags.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (r_rv0) begin
            rvalid[r_ri0]                  = 1'b1;
            rdata[r_ri0*DBITS +: DBITS]    = Q0;
        end
        if (r_rv1) begin
            rvalid[r_ri1]                  = 1'b1;
            rdata[r_ri1*DBITS +: DBITS]    = Q1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_rr    <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_ri0   <= '0;
            r_ri1   <= '0;
        end else begin
            r_rv0 <= w_g0 && !we[w_i0];
            r_ri0 <= w_i0;
            r_rv1 <= w_g1 && !we[w_i1];
            r_ri1 <= w_i1;
            case (r_state)
                CLEAR: begin
                    if (r_ptr == ABITS'(WORDS - 2)) begin
                        r_state <= RUN;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + ABITS'(2);
                    end
                end
                RUN: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                    if (w_g1) begin
                        r_rr <= wrap_inc(w_i1);
                    end else if (w_g0) begin
                        r_rr <= wrap_inc(w_i0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsram_8192x2_arb.sv
// Bench for gsram_8192x2_arb: SRAM model, directed vector table, hand-built
// clear/reset sequences and a randomized run against a reference model.
module tb_gsram_8192x2_arb;

    localparam int N = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          clr = 1'b0;
    logic          busy;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  we = '0;
    logic [N*13-1:0] addr = '0;
    logic [N*2-1:0]  wdata = '0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [N*2-1:0] rdata;
    logic [12:0]   A0, A1;
    logic [1:0]    D0, D1;
    logic          WE0, WE1, CE0, CE1;
    logic [1:0]    Q0 = '0;
    logic [1:0]    Q1 = '0;

    always #5 CLK = ~CLK;

    gsram_8192x2_arb #(.NREQ(N)) dut (
        .CLK(CLK), .RSTN(RSTN), .clr(clr), .busy(busy),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0),
        .A1(A1), .D1(D1), .WE1(WE1), .CE1(CE1),
        .Q0(Q0), .Q1(Q1)
    );

    // Synchronous SRAM, non-zero power-up contents so the clear is observable.
    logic [1:0] mem [8192] = '{default: 2'b11};
    bit         wr_seen [8192];
    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0) begin mem[A0] <= D0; wr_seen[A0] <= 1'b1; end
            else Q0 <= mem[A0];
        end
        if (CE1) begin
            if (WE1) begin mem[A1] <= D1; wr_seen[A1] <= 1'b1; end
            else Q1 <= mem[A1];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Staged requester inputs, applied on the falling edge.
    logic [3:0]  s_req, s_we;
    logic        s_clr;
    logic [12:0] s_addr [4];
    logic [1:0]  s_wd [4];

    // Reference model state and per-cycle expectations.
    int          m_rr, m_left;
    logic [1:0]  m_mem [8192];
    logic [3:0]  m_pv;
    logic [7:0]  m_pd;
    logic [3:0]  e_gnt, e_rvalid;
    logic [7:0]  e_rdata;
    logic        e_busy;
    logic [1:0]  e_ce;

    task automatic apply();
        req = s_req; we = s_we; clr = s_clr;
        for (int i = 0; i < N; i++) begin
            addr[i*13 +: 13] = s_addr[i];
            wdata[i*2 +: 2]  = s_wd[i];
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_left = 4096; m_pv = '0; m_pd = '0;
        for (int a = 0; a < 8192; a++) m_mem[a] = 2'b00;
    endtask

    // One cycle: drive at negedge, settle, derive expectations from the rules.
    task automatic step();
        int w [2];
        int nw;
        @(negedge CLK);
        apply();
        #1;
        nw = 0;
        e_busy = (m_left > 0);
        e_rvalid = m_pv; e_rdata = m_pd; e_gnt = '0;
        m_pv = '0; m_pd = '0;
        if (e_busy) begin
            m_left--;
        end else if (s_clr) begin
            m_left = 4096;
            for (int a = 0; a < 8192; a++) m_mem[a] = 2'b00;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (s_req[i] && nw < 2) begin w[nw] = i; nw++; end
            end
            if (nw == 2 && s_addr[w[0]] == s_addr[w[1]] && (s_we[w[0]] || s_we[w[1]]))
                nw = 1;
            for (int j = 0; j < nw; j++) begin
                e_gnt[w[j]] = 1'b1;
                if (s_we[w[j]]) m_mem[s_addr[w[j]]] = s_wd[w[j]];
                else begin
                    m_pv[w[j]] = 1'b1;
                    m_pd[w[j]*2 +: 2] = m_mem[s_addr[w[j]]];
                end
            end
            if (nw > 0) m_rr = (w[nw-1] + 1) % N;
        end
        e_ce = e_busy ? 2'b11 : (nw == 0) ? 2'b00 : (nw == 1) ? 2'b01 : 2'b11;
    endtask

    task automatic do_reset(input bit at_edge);
        if (at_edge) @(negedge CLK);
        RSTN = 1'b0;
        apply();
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ports", 32'({|A0, |A1, |D0, |D1, WE0, WE1, CE0, CE1}), 32'd0);
        model_reset();
        repeat (3) @(posedge CLK);
        #2 RSTN = 1'b1;
    endtask

    // Walk a clear with requests pending; stop_at >= 0 returns early at that cycle.
    task automatic run_clear(input int stop_at, output int cyc, output int bad);
        cyc = 0; bad = 0;
        for (int i = 0; i < N; i++) begin s_addr[i] = 13'(i); s_wd[i] = 2'b00; end
        s_we = '0;
        for (int n = 0; n < 5000; n++) begin
            s_req = (cyc < 4000) ? 4'hF : 4'h0;
            s_clr = (cyc == 100);
            step();
            if (!busy) return;
            if (A0 !== 13'(2*cyc) || A1 !== 13'(2*cyc + 1) || CE0 !== 1'b1 || CE1 !== 1'b1
                || WE0 !== 1'b1 || WE1 !== 1'b1 || D0 !== 2'b00 || D1 !== 2'b00
                || gnt !== '0 || rvalid !== '0)
                bad++;
            if (cyc == stop_at) return;
            cyc++;
        end
    endtask

    typedef struct packed {
        logic [3:0]  rq;
        logic [3:0]  wv;
        logic [51:0] ad;
        logic [7:0]  wd;
        logic [3:0]  g;
        logic [3:0]  rv;
        logic [7:0]  rd;
        logic [1:0]  ce;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] wv,
                                input logic [12:0] a0, input logic [12:0] a1,
                                input logic [12:0] a2, input logic [12:0] a3,
                                input logic [7:0] wd, input logic [3:0] g,
                                input logic [3:0] rv, input logic [7:0] rd,
                                input logic [1:0] ce);
        vec_t v;
        v.rq = rq; v.wv = wv; v.ad = {a3, a2, a1, a0}; v.wd = wd;
        v.g = g; v.rv = rv; v.rd = rd; v.ce = ce;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, bad, nz;
        s_req = 4'hF; s_we = '0; s_clr = 1'b0;
        for (int i = 0; i < N; i++) begin s_addr[i] = 13'(i); s_wd[i] = '0; end

        // Reset state, then the power-up clear with requests and a stray clr pending.
        do_reset(1'b1);
        run_clear(-1, cyc, bad);
        chk("clear_len", 32'(cyc), 32'd4096);
        chk("clear_seq", 32'(bad), 32'd0);
        nz = 0;
        for (int a = 0; a < 8192; a++) if (mem[a] !== 2'b00 || !wr_seen[a]) nz++;
        chk("clear_mem", 32'(nz), 32'd0);

        // Directed vectors: round-robin pairs, conflicts, shared reads, single requester.
        tbl[0]  = mk(4'hF, 4'hF, 13'h20, 13'h21, 13'h22, 13'h23, 8'h79, 4'h3, 4'h0, 8'h00, 2'b11);
        tbl[1]  = mk(4'hC, 4'hF, 13'h20, 13'h21, 13'h22, 13'h23, 8'h79, 4'hC, 4'h0, 8'h00, 2'b11);
        tbl[2]  = mk(4'hF, 4'h0, 13'h20, 13'h21, 13'h22, 13'h23, 8'h00, 4'h3, 4'h0, 8'h00, 2'b11);
        tbl[3]  = mk(4'hF, 4'h0, 13'h20, 13'h21, 13'h22, 13'h23, 8'h00, 4'hC, 4'h3, 8'h09, 2'b11);
        tbl[4]  = mk(4'hF, 4'h0, 13'h20, 13'h21, 13'h22, 13'h23, 8'h00, 4'h3, 4'hC, 8'h70, 2'b11);
        tbl[5]  = mk(4'h0, 4'h0, 13'h20, 13'h21, 13'h22, 13'h23, 8'h00, 4'h0, 4'h3, 8'h09, 2'b00);
        tbl[6]  = mk(4'h3, 4'h1, 13'h10, 13'h10, 13'h0, 13'h0, 8'h03, 4'h1, 4'h0, 8'h00, 2'b01);
        tbl[7]  = mk(4'h2, 4'h0, 13'h10, 13'h10, 13'h0, 13'h0, 8'h03, 4'h2, 4'h0, 8'h00, 2'b01);
        tbl[8]  = mk(4'h0, 4'h0, 13'h0, 13'h0, 13'h0, 13'h0, 8'h00, 4'h0, 4'h2, 8'h0C, 2'b00);
        tbl[9]  = mk(4'h4, 4'h4, 13'h0, 13'h0, 13'h100, 13'h100, 8'h20, 4'h4, 4'h0, 8'h00, 2'b01);
        tbl[10] = mk(4'hC, 4'h0, 13'h0, 13'h0, 13'h100, 13'h100, 8'h00, 4'hC, 4'h0, 8'h00, 2'b11);
        tbl[11] = mk(4'h0, 4'h0, 13'h0, 13'h0, 13'h0, 13'h0, 8'h00, 4'h0, 4'hC, 8'hA0, 2'b00);
        tbl[12] = mk(4'h1, 4'h0, 13'h20, 13'h0, 13'h0, 13'h0, 8'h00, 4'h1, 4'h0, 8'h00, 2'b01);
        tbl[13] = mk(4'h1, 4'h0, 13'h20, 13'h0, 13'h0, 13'h0, 8'h00, 4'h1, 4'h1, 8'h01, 2'b01);
        tbl[14] = mk(4'h1, 4'h0, 13'h20, 13'h0, 13'h0, 13'h0, 8'h00, 4'h1, 4'h1, 8'h01, 2'b01);
        tbl[15] = mk(4'h0, 4'h0, 13'h20, 13'h0, 13'h0, 13'h0, 8'h00, 4'h0, 4'h1, 8'h01, 2'b00);
        tbl[16] = mk(4'h1, 4'h0, 13'h1FFF, 13'h0, 13'h0, 13'h0, 8'h00, 4'h1, 4'h0, 8'h00, 2'b01);
        tbl[17] = mk(4'h0, 4'h0, 13'h0, 13'h0, 13'h0, 13'h0, 8'h00, 4'h0, 4'h1, 8'h00, 2'b00);
        for (int r = 0; r < 18; r++) begin
            s_req = tbl[r].rq; s_we = tbl[r].wv; s_clr = 1'b0;
            for (int i = 0; i < N; i++) begin
                s_addr[i] = tbl[r].ad[i*13 +: 13];
                s_wd[i]   = tbl[r].wd[i*2 +: 2];
            end
            step();
            chk($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(tbl[r].g));
            chk($sformatf("vec%0d_rvalid", r), 32'(rvalid), 32'(tbl[r].rv));
            chk($sformatf("vec%0d_rdata", r), 32'(rdata), 32'(tbl[r].rd));
            chk($sformatf("vec%0d_ce", r), 32'({CE1, CE0}), 32'(tbl[r].ce));
        end

        // Randomized traffic over a small address window; requests held until granted.
        s_req = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_rvalid", 32'(rvalid), 32'(e_rvalid));
            chk("rnd_rdata", 32'(rdata), 32'(e_rdata));
            chk("rnd_ce", 32'({CE1, CE0}), 32'(e_ce));
            chk("rnd_busy", 32'(busy), 32'(e_busy));
            for (int i = 0; i < N; i++) begin
                if (!(s_req[i] && !e_gnt[i])) begin
                    s_req[i]  = ($urandom_range(0, 99) < 55);
                    s_we[i]   = 1'($urandom_range(0, 1));
                    s_addr[i] = 13'($urandom_range(0, 7));
                    s_wd[i]   = 2'($urandom_range(0, 3));
                end
            end
        end
        s_req = '0;
        step();
        chk("rnd_drain_rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("rnd_drain_rdata", 32'(rdata), 32'(e_rdata));

        // clr in RUN: no grant that cycle, prior read still returns, then a full clear.
        s_req = 4'h1; s_we = '0; s_addr[0] = 13'h5;
        step();
        chk("clr_pre_gnt", 32'(gnt), 32'h1);
        s_req = 4'hF; s_clr = 1'b1;
        step();
        chk("clr_no_gnt", 32'(gnt), 32'h0);
        chk("clr_busy_lo", 32'(busy), 32'h0);
        chk("clr_rvalid", 32'(rvalid), 32'h1);
        chk("clr_rdata", 32'(rdata), 32'(e_rdata));
        s_clr = 1'b0;
        run_clear(-1, cyc, bad);
        chk("clr2_len", 32'(cyc), 32'd4096);
        chk("clr2_seq", 32'(bad), 32'd0);

        // Reset with a read in flight drops its rvalid.
        s_req = 4'h2; s_we = '0; s_addr[1] = 13'h5;
        step();
        chk("mr_gnt", 32'(gnt), 32'h2);
        s_req = '0;
        do_reset(1'b1);

        // Reset at clear pointer 0x0800 restarts the clear from address 0.
        run_clear(32'h400, cyc, bad);
        chk("abort_ptr", 32'(A0), 32'h800);
        chk("abort_seq", 32'(bad), 32'd0);
        do_reset(1'b0);
        run_clear(-1, cyc, bad);
        chk("restart_len", 32'(cyc), 32'd4096);
        chk("restart_seq", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
